// File: rtl/ssd_scan_if.sv
// Load/status/pin bundle between score logic and the seven-segment scan driver.
// The master drives value/load; the slave returns status and the registered display pins.
interface ssd_scan_if #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned VALUE_W    = 14
);
    logic [VALUE_W-1:0]    value;
    logic                  load;
    logic                  busy;
    logic                  overflow;
    logic [6:0]            segs;
    logic [NUM_DIGITS-1:0] anodes;

    modport master (
        output value, load,
        input  busy, overflow, segs, anodes
    );

    modport slave (
        input  value, load,
        output busy, overflow, segs, anodes
    );
endinterface

// File: rtl/ssd_scan_driver.sv
// Multi-digit seven-segment scan driver: sequential binary-to-BCD conversion (shift-add-3)
// feeding a scanned display. Optional leading-zero blanking under `define SSD_LZB_EN.
module ssd_scan_driver #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned VALUE_W    = 14,
    parameter int unsigned SCAN_DIV   = 50000
) (
    input logic        clock,
    input logic        resetn,
    ssd_scan_if.slave  bus
);
    // Decimal digits needed for the largest VALUE_W-bit value.
    function automatic int unsigned dec_digits(input int unsigned w);
        longint unsigned m;
        int unsigned     n;
        m = (64'd1 << w) - 64'd1;
        n = 0;
        while (m != 64'd0) begin
            m = m / 64'd10;
            n = n + 1;
        end
        return (n == 0) ? 1 : n;
    endfunction

    localparam int unsigned ACC_MIN = dec_digits(VALUE_W);
    localparam int unsigned ACC_NIB = (ACC_MIN > NUM_DIGITS) ? ACC_MIN : NUM_DIGITS;
    localparam int unsigned ACC_W   = ACC_NIB * 4;
    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W   = $clog2(SCAN_DIV);
    localparam int unsigned BIT_W   = $clog2(VALUE_W + 1);

    typedef enum logic [1:0] {StIdle, StConv, StCommit} state_e;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    state_e                      state_q;
    logic                        busy_q, ovf_q;
    logic [VALUE_W-1:0]          sh_q;
    logic [ACC_W-1:0]            acc_q;
    logic [BIT_W-1:0]            bit_q;
    logic [NUM_DIGITS-1:0][3:0]  disp_q;

    logic [ACC_W-1:0]            acc_adj, acc_next;
    logic                        ovf_next;

    always_comb begin
        acc_adj = acc_q;
        for (int unsigned i = 0; i < ACC_NIB; i++) begin
            if (acc_q[i*4 +: 4] >= 4'd5) acc_adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
        end
        acc_next = {acc_adj[ACC_W-2:0], sh_q[VALUE_W-1]};
        // Any nonzero nibble above the displayed ones means the value did not fit.
        ovf_next = 1'b0;
        for (int unsigned i = NUM_DIGITS; i < ACC_NIB; i++) begin
            if (acc_q[i*4 +: 4] != 4'd0) ovf_next = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            sh_q    <= '0;
            acc_q   <= '0;
            bit_q   <= '0;
            disp_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.load) begin
                        sh_q    <= bus.value;
                        acc_q   <= '0;
                        bit_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StConv;
                    end
                end
                StConv: begin
                    acc_q <= acc_next;
                    sh_q  <= sh_q << 1;
                    bit_q <= bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(VALUE_W - 1)) state_q <= StCommit;
                end
                StCommit: begin
                    disp_q  <= acc_q[NUM_DIGITS*4-1:0];
                    ovf_q   <= ovf_next;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic [6:0]            segs_q, seg_sel;
    logic [NUM_DIGITS-1:0] anodes_q;
    logic                  blank;

    always_comb begin
        blank = 1'b0;
`ifdef SSD_LZB_EN
        // Blank when this digit and every digit above it are zero; digit 0 always shows.
        blank = (idx_q != '0);
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (i >= 32'(idx_q) && disp_q[i] != 4'd0) blank = 1'b0;
        end
`endif
        if (ovf_q) begin
            seg_sel = 7'h3F;
        end else if (blank) begin
            seg_sel = 7'h7F;
        end else begin
            seg_sel = decode(disp_q[idx_q]);
        end
    end

    // Pins reload only at slot start, so a commit mid-slot shows from the next slot.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            segs_q   <= 7'h7F;
            anodes_q <= '1;
        end else begin
            if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
                cnt_q <= '0;
                idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (cnt_q == '0) begin
                anodes_q <= ~(NUM_DIGITS'(1) << idx_q);
                segs_q   <= seg_sel;
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.overflow = ovf_q;
    assign bus.segs     = segs_q;
    assign bus.anodes   = anodes_q;
endmodule

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
- Multi-digit, time-multiplexed seven-segment display driver. Successor to the team's single-digit combinational decoder.
- Accepts a binary value on a load strobe and converts it to BCD sequentially with shift-add-3, one bit per cycle.
- Latches the BCD result into a display register and scans the digits onto shared active-low segment lines with one active-low digit enable per digit.
- Sits between game/score logic and the board's display pins.

Parameters:
NUM_DIGITS, 4, number of display digits scanned (1..8)
VALUE_W, 14, width of binary input value
SCAN_DIV, 50000, clock cycles each digit is held active before advancing (>=2)

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
value  input  VALUE_W  binary value to display, sampled on accepted load
load  input  1  single-cycle request to convert and display value
busy  output  1  high while a conversion is in progress
overflow  output  1  high when last completed value exceeded 10^NUM_DIGITS-1
segs  output  7  active-low segments {g,f,e,d,c,b,a}, registered
anodes  output  NUM_DIGITS  active-low digit enables, one-hot-low, registered

Behaviour:
- Reset (resetn low, async) forces the following. Release is synchronous to clock.
  - busy=0, overflow=0, FSM=IDLE.
  - Display register = all-zero BCD; scan index=0; scan counter=0.
  - segs=7'h7F (blank), anodes=all 1s.
- Reset mid-conversion aborts the conversion. The display register returns to zero.
- FSM states:
  - IDLE: on load=1, capture value into the shift register, clear the BCD accumulator, busy=1 next cycle, go to CONV. load while busy (CONV/COMMIT) is ignored and not queued.
  - CONV: each cycle, add 3 to every BCD nibble >=5, then shift the accumulator left one bit, taking the MSB of the shift register. Runs exactly VALUE_W cycles, then go to COMMIT.
  - COMMIT: one cycle. Copy all NUM_DIGITS nibbles atomically into the display register. Set overflow if captured value > 10^NUM_DIGITS-1, else clear it. busy=0 on the following cycle; return to IDLE.
- Load-to-display latency: busy rises 1 cycle after load and stays high VALUE_W+1 cycles. The new digits are visible from the first scan slot after COMMIT. The display never shows partially converted digits.
- Accumulator arithmetic:
  - The accumulator is internally wide enough for the full VALUE_W range: ceil(VALUE_W*log10(2)) nibbles.
  - Only the low NUM_DIGITS nibbles are displayed.
- Overflow display: while overflow=1, every digit shows minus (segment g only lit, segs=7'b0111111).
- Scan:
  - The scan counter counts 0..SCAN_DIV-1. On wrap, the scan index advances, wrapping NUM_DIGITS-1 -> 0.
  - Digit 0 is the least significant digit.
  - anodes[i]=0 only when index==i.
  - segs carries the decode of the selected nibble, registered with anodes in the same cycle.
  - Scanning runs continuously, independent of the FSM state.
- Decode (active-low):
  - 0:7'h40, 1:7'h79, 2:7'h24, 3:7'h30, 4:7'h19
  - 5:7'h12, 6:7'h02, 7:7'h78, 8:7'h00, 9:7'h10
  - Nibbles 10-15 (unreachable) show blank 7'h7F.
- Simultaneous events: load accepted in the same cycle as a scan advance has no interaction. A scan slot that begins on the COMMIT edge uses the old digits; the new digits appear from the next slot.

Optional Feature:
- Macro: SSD_LZB_EN (leading-zero blanking).
- Defined:
  - Any digit above the most significant nonzero digit shows blank (7'h7F) instead of 0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Blanking is not applied while overflow=1.
  - Its anode still activates in its slot.
- Undefined: all NUM_DIGITS digits are always shown, including leading zeros.

Test Plan:
- Reset: assert resetn=0 mid-scan -> segs=7'h7F, anodes=4'hF, busy=0 immediately. After release, digit 0 shows 7'h40 within SCAN_DIV cycles.
- Conversion: load value=1234 (SCAN_DIV=4) -> busy high exactly 15 cycles. Then digits 3..0 show 7'h79, 7'h24, 7'h30, 7'h19. overflow=0.
- Overflow: load value=10000 with NUM_DIGITS=4 -> overflow=1, all four digits 7'h3F. A subsequent load of 42 -> overflow=0, digits show 0,0,4,2.
- Load ignored: second load pulse with value=9999 two cycles into the conversion of 7 -> display shows 0007; busy deasserts once, after 15 cycles.
- Scan wrap: SCAN_DIV=3, NUM_DIGITS=4 -> anodes sequence E,D,B,7,E each held 3 cycles. Exactly one anode low every cycle after the first slot.
- SSD_LZB_EN defined: load 7 -> digits 3..1 blank 7'h7F, digit 0 7'h78. Load 0 -> only digit 0 shows 7'h40.
